// File: rtl/bram_arb_pkg.sv
// Shared definitions for the block-RAM round-robin arbiter: default geometry
// and the INIT/RUN state encoding.
package bram_arb_pkg;

   localparam int DEF_ADDR_W = 9;
   localparam int DEF_DATA_W = 32;
   localparam int DEPTH      = 2 ** DEF_ADDR_W;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Width of a requester index for n requesters (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bram_rr_arbiter_rr_pick.sv
// Combinational round-robin select: the first set request at or above ptr,
// wrapping around, as a one-hot grant and an index.
module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   int               pos;
   logic [PTR_W-1:0] pos_idx;

   // Walk from the farthest slot back to ptr so the nearest request wins last.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      any     = 1'b0;
      pos     = 0;
      pos_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         pos_idx = PTR_W'(pos);
         if (req[pos_idx]) begin
            gnt          = '0;
            gnt[pos_idx] = 1'b1;
            idx          = pos_idx;
            any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among NUM_REQ requesters,
// with optional zero-fill after reset and fixed two-cycle read responses.
module bram_rr_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_din,
   input  logic [DATA_W-1:0]         mem_dout,
   output logic                      init_done
);

   localparam int PTR_W     = idx_width(NUM_REQ);
   localparam int LAST_ADDR = 2 ** ADDR_W - 1;

   state_t             state;
   logic [ADDR_W-1:0]  cnt;
   logic [PTR_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] gnt;
   logic [PTR_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic               run;
   logic               acc;
   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic               vld_p1, vld_p2;
   logic [PTR_W-1:0]   id_p1, id_p2;

   rr_pick #(
      .N    (NUM_REQ),
      .PTR_W(PTR_W)
   ) u_pick (
      .req(req_valid),
      .ptr(rr_ptr),
      .gnt(gnt),
      .idx(gnt_idx),
      .any(gnt_any)
   );

   // Grants are suppressed while reset is held so nothing is ever accepted then.
   assign run       = (state == ST_RUN) && !rst;
   assign req_ready = run ? gnt : '0;
   assign acc       = run && gnt_any;

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Stage p0 -> p1: winning request onto the RAM port; read tag enters pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
         cnt       <= '0;
         rr_ptr    <= '0;
         init_done <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               mem_we   <= 1'b1;
               mem_addr <= cnt;
               mem_din  <= '0;
               cnt      <= cnt + 1'b1;
               if (cnt == ADDR_W'(LAST_ADDR)) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            default: begin
               init_done <= 1'b1;
               mem_we    <= acc && sel_we;
               if (acc) begin
                  mem_addr <= sel_addr;
                  mem_din  <= sel_wdata;
                  rr_ptr   <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
               end
            end
         endcase
         vld_p1 <= acc && !sel_we;
         vld_p2 <= vld_p1;
      end
   end

   // Stage p1 -> p2: requester id follows the RAM's registered read.
   always_ff @(posedge clk) begin
      id_p1 <= gnt_idx;
      id_p2 <= id_p1;
   end

   always_comb begin
      rsp_valid = '0;
      if (vld_p2) rsp_valid[id_p2] = 1'b1;
   end

   assign rsp_rdata = mem_dout;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Scoreboard bench for bram_rr_arbiter with a behavioural RAM and a
// specification-level model of arbitration and memory contents.
module tb_bram_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 9;
   localparam int DW = 32;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, mem_din, mem_dout;
   logic [AW-1:0]   mem_addr;
   logic            mem_we, init_done;

   logic [AW-1:0] a_addr  [N];
   logic [DW-1:0] a_wdata [N];
   logic [DW-1:0] ram     [2**AW];

   typedef struct {
      int          id;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          glog[$];
   logic [31:0] ref_mem [2**AW];
   logic [N-1:0] acc_flag;
   int          m_ptr;
   bit          run_chk;
   bit          prev_acc, prev_we;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_din;
   int          cyc = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   int          start;

   bram_rr_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .INIT_ON_RESET(1'b1)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .init_done(init_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW]  = a_addr[i];
         req_wdata[i*DW +: DW] = a_wdata[i];
      end
   end

   // Behavioural RAM port with registered read data.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: grant = first valid requester from the pointer upward.
   always @(negedge clk) begin
      if (run_chk) begin
         int g;
         logic [N-1:0] exp_rdy;
         g = -1;
         for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("req_ready", req_ready, exp_rdy);
         if (prev_acc) begin
            chk("mem_we", mem_we, prev_we);
            chk("mem_addr", mem_addr, prev_addr);
            if (prev_we) chk("mem_din", mem_din, prev_din);
         end else begin
            chk("mem_we_idle", mem_we, 0);
         end
         prev_acc = 0;
         if (g >= 0) begin
            prev_acc  = 1;
            prev_we   = req_we[g];
            prev_addr = a_addr[g];
            prev_din  = a_wdata[g];
            if (req_we[g]) ref_mem[a_addr[g]] = a_wdata[g];
            else q.push_back('{g, ref_mem[a_addr[g]], cyc});
            glog.push_back(g);
            acc_flag[g] = 1'b1;
            m_ptr = (g + 1) % N;
         end
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      if (run_chk) begin
         if (rsp_valid != '0) begin
            if (q.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 0);
            end else begin
               exp_t e;
               logic [N-1:0] oh;
               e = q.pop_front();
               oh = '0;
               oh[e.id] = 1'b1;
               chk("rsp_id", rsp_valid, oh);
               chk("rsp_data", rsp_rdata, e.data);
               chk("rsp_latency", cyc - e.cyc, 2);
            end
         end else if (q.size() > 0 && cyc - q[0].cyc >= 2) begin
            chk("rsp_missing", 0, 1);
            void'(q.pop_front());
         end
      end
   end

   task automatic run_init();
      req_valid = '1;
      req_we    = '0;
      for (int k = 0; k < 2**AW; k++) begin
         @(negedge clk);
         chk("init_ready", req_ready, 0);
         chk("init_done_low", init_done, 0);
         chk("init_rsp", rsp_valid, 0);
         if (k == 0) begin
            chk("init_we_first", mem_we, 0);
         end else begin
            chk("init_we", mem_we, 1);
            chk("init_addr", mem_addr, k - 1);
            chk("init_din", mem_din, 0);
         end
         if (k == 2**AW - 1) req_valid = '0;
      end
      @(negedge clk);
      chk("init_done_high", init_done, 1);
      chk("init_last_we", mem_we, 1);
      chk("init_last_addr", mem_addr, 2**AW - 1);
      for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
      m_ptr    = 0;
      prev_acc = 0;
      acc_flag = '0;
      q.delete();
      glog.delete();
      #1 run_chk = 1;
   endtask

   // Issue one request and hold it until accepted; returns in the next cycle.
   task automatic do_req(input int i, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] d);
      req_we[i]  = we;
      a_addr[i]  = addr;
      a_wdata[i] = d;
      req_valid[i] = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(posedge clk);
         #1;
         if (acc_flag[i]) begin
            acc_flag[i]  = 1'b0;
            req_valid[i] = 1'b0;
            return;
         end
      end
      chk("req_timeout", 0, 1);
      req_valid[i] = 1'b0;
   endtask

   // Keep the masked requesters continuously valid with reads until cnt grants.
   task automatic run_set(input logic [N-1:0] mask, input int cnt);
      glog.delete();
      for (int i = 0; i < N; i++) begin
         req_we[i] = 1'b0;
         a_addr[i] = AW'($urandom_range(0, 15));
      end
      req_valid = mask;
      for (int t = 0; t < 100 && glog.size() < cnt; t++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++)
            if (acc_flag[i]) begin
               acc_flag[i] = 1'b0;
               a_addr[i] = AW'($urandom_range(0, 15));
            end
      end
      if (glog.size() < cnt) chk("set_timeout", glog.size(), cnt);
      req_valid = '0;
      acc_flag  = '0;
   endtask

   initial begin
      clk = 0;
      rst = 1;
      run_chk = 0;
      req_valid = '0;
      req_we = '0;
      acc_flag = '0;
      for (int i = 0; i < N; i++) begin
         a_addr[i]  = '0;
         a_wdata[i] = '0;
      end
      for (int i = 0; i < 2**AW; i++) ram[i] = $urandom;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      run_init();
      @(posedge clk);
      #1;

      do_req(0, 1'b0, 9'd5, '0);
      do_req(2, 1'b1, 9'h1A3, 32'hDEADBEEF);
      do_req(2, 1'b0, 9'h1A3, '0);
      for (int a = 0; a < 16; a++) do_req(a % N, 1'b1, AW'(a), $urandom);

      start = m_ptr;
      run_set(4'b1111, 8);
      for (int k = 0; k < 8; k++) chk("fair_order", glog[k], (start + k) % N);

      do_req(0, 1'b1, 9'd7, 32'h11);
      do_req(1, 1'b0, 9'd7, '0);

      run_set(4'b1010, 4);
      for (int k = 0; k < 4; k++) begin
         chk("skip_member", (glog[k] == 1 || glog[k] == 3), 1);
         if (k > 0) chk("skip_alternate", glog[k] != glog[k-1], 1);
      end

      for (int t = 0; t < 400; t++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc_flag[i]) begin
               acc_flag[i]  = 1'b0;
               req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
               req_we[i]    = 1'($urandom_range(0, 1));
               a_addr[i]    = AW'($urandom_range(0, 15));
               a_wdata[i]   = $urandom;
               req_valid[i] = 1'b1;
            end
         end
      end
      for (int t = 0; t < 50 && req_valid != '0; t++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++)
            if (acc_flag[i]) begin
               acc_flag[i]  = 1'b0;
               req_valid[i] = 1'b0;
            end
      end
      chk("drain_requests", req_valid, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("queue_empty_mid", q.size(), 0);

      // Reset lands the cycle after a read is accepted; its response must vanish.
      do_req(2, 1'b0, 9'd3, '0);
      rst = 1;
      run_chk = 0;
      q.delete();
      prev_acc = 0;
      @(posedge clk);
      #1 rst = 0;
      run_init();
      @(posedge clk);
      #1;
      run_set(4'b1111, 8);
      for (int k = 0; k < 8; k++) chk("fair_after_reset", glog[k], k % N);

      repeat (6) @(posedge clk);
      #1;
      chk("queue_empty_end", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Round-robin arbiter that shares one port of the team's 512x32 dual-port block RAM among NUM_REQ requesters on a single clock.
- Accepts read/write requests through per-requester valid/ready handshakes and registers the winning request onto the RAM port.
- Routes read data back to the issuing requester with a fixed latency.
- Can optionally zero-fill the whole RAM after reset, before accepting any traffic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 9, RAM address width; depth is 2**ADDR_W.
- DATA_W, 32, RAM data width.
- INIT_ON_RESET, 1, when 1, zero-fill the RAM after reset before granting.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- rsp_valid  out  NUM_REQ  one-cycle pulse marking read data for requester i.
- rsp_rdata  out  DATA_W  read data; shared by all requesters, qualified by rsp_valid.
- mem_we  out  1  RAM port write enable, registered.
- mem_addr  out  ADDR_W  RAM port address, registered.
- mem_din  out  DATA_W  RAM port write data, registered.
- mem_dout  in  DATA_W  RAM port registered read data.
- init_done  out  1  high once the arbiter is in RUN.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, mem_we=0, mem_addr=0, mem_din=0, init_done=0, rr_ptr=0, init counter=0.
- State machine has two states, INIT and RUN.
  - After reset the state is INIT if INIT_ON_RESET=1, otherwise RUN.
- INIT:
  - req_ready=0.
  - Each cycle drives mem_we=1, mem_addr=cnt, mem_din=0, then cnt increments.
  - After issuing address 2**ADDR_W-1, the state moves to RUN and init_done becomes 1 on that same edge.
  - INIT therefore lasts exactly 2**ADDR_W cycles.
- RUN arbitration, combinational in the cycle:
  - The grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
  - req_ready[grant]=1; all other ready bits are 0.
  - No valid requests means no grant.
  - Acceptance is the cycle where valid and ready are both 1.
  - Requesters hold valid, we, addr and wdata stable until accepted; valid must not depend on ready.
- On acceptance at cycle T:
  - rr_ptr <= (grant+1) mod NUM_REQ.
  - mem_we/addr/din take the request values at the edge ending T; they drive the RAM in cycle T+1.
- Idle cycle: mem_we=0; mem_addr and mem_din hold their last values.
- Read latency:
  - The RAM registers mem_dout at the edge ending T+1.
  - rsp_valid[grant] pulses in T+2, with rsp_rdata = mem_dout passed through combinationally.
  - A 2-stage pipeline of {is_read, requester id} carries the tag.
  - Accepted reads are 2 cycles from acceptance to response; throughput is one request per cycle.
- Writes produce no response.
- Ordering:
  - A write accepted at T is visible to any read accepted at T+1 or later.
  - Same-cycle read/write on the same port does not occur; the other RAM port is out of scope.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- Reset mid-operation:
  - All in-flight response tags are dropped and no rsp_valid fires.
  - rr_ptr returns to 0.
  - INIT re-runs if INIT_ON_RESET=1.

Decomposition:
- Package bram_arb_pkg holds:
  - Defaults for ADDR_W=9 and DATA_W=32.
  - The state encoding ST_INIT=1'b0, ST_RUN=1'b1.
  - The constant DEPTH=2**ADDR_W.
- One sub-module, rr_pick: combinational round-robin priority select taking (req vector, rr_ptr) and producing a one-hot grant plus a grant index.

Test Plan:
- Init: INIT_ON_RESET=1, release rst -> req_ready stays 0 for 512 cycles; mem_we=1 with addr 0..511 and din=0; init_done rises after address 511; afterwards a read of address 5 returns 0.
- Single write then read: requester 2 writes 0xDEADBEEF to address 0x1A3, then reads 0x1A3 -> rsp_valid[2] pulses exactly 2 cycles after read acceptance with rsp_rdata=0xDEADBEEF; no other rsp_valid bits fire.
- Fairness: all four requesters hold valid reads for 8 cycles, rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3; each requester gets 2 responses with the correct data.
- Back-to-back: requester 0 writes 0x11 to addr 7 at T, requester 1 reads addr 7 at T+1 -> rsp_rdata=0x11 at T+3.
- Skip idle requesters: only requesters 1 and 3 valid -> grants alternate 1,3,1,3; ready never asserts for 0 or 2.
- Reset mid-flight: read accepted at T, rst asserted at T+1 -> no rsp_valid in T+2; after reset, rr_ptr=0 and INIT re-runs.
